// File: rtl/sat_alu_pkg.sv
// Shared types and helpers for the saturating add/sub/accumulate pipeline.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sat_alu_pkg;

   // Operation encoding as presented on the op port
   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_ACC  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   // Result flags travelling alongside the saturated value
   typedef struct packed {
      logic zr;
      logic neg;
      logic ov;
   } flags_t;

   // Widest operand the helper functions can describe
   localparam int SAT_MAX_W = 64;

   // Largest positive two's-complement value of width w (0 followed by all 1s)
   function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned w);
      return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
   endfunction

   // Most negative two's-complement value of width w (1 followed by all 0s)
   function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned w);
      return SAT_MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/sat_add_core.sv
// Saturating two's-complement adder a + b + cin with Z/N/V flags.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module sat_add_core
   import sat_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] res,
   output flags_t           flags
);

   localparam int              MSB   = WIDTH - 1;
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(sat_max(WIDTH));
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(sat_min(WIDTH));

   logic [WIDTH-1:0] sum;
   logic             ovf;

   // Wrapping add, overflow detect from operand/result signs, then clamp
   always_comb begin
      sum       = a + b + WIDTH'(cin);
      // Same-signed operands whose sum flips sign have overflowed; b is
      // already inverted for subtraction, so SUB of MIN is covered too.
      ovf       = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      res       = sum;
      flags.zr  = (sum == '0);
      flags.neg = sum[MSB];
      flags.ov  = 1'b0;
      if (ovf) begin
         // Overflow direction follows the sign of the operands
         res       = a[MSB] ? MIN_V : MAX_V;
         flags.ov  = 1'b1;
         flags.neg = a[MSB];
         flags.zr  = 1'b0;
      end
   end

endmodule

// File: rtl/sat_alu_pipe.sv
// Two-stage saturating ADD/SUB/ACC/LOAD unit with accumulator, Z/N/V flags and optional sticky overflow (SAT_ALU_STICKY_OV_EN).
// Latency: result valid two edges after the op is offered (S1 register, then S2 output register); 1 op/cycle.
// Backpressure: out_rdy low stalls S2, then S1; in_rdy drops once both stages hold ops, nothing is dropped.
module sat_alu_pipe
   import sat_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             neg,
   output logic             ov,
   output logic [WIDTH-1:0] acc,
   input  logic             ov_clr,
   output logic             ov_sticky
);

   // Stage 1: captured operation
   logic             s1_vld_q,  s1_vld_d;
   op_e              s1_op_q,   s1_op_d;
   logic [WIDTH-1:0] s1_in1_q,  s1_in1_d;
   logic [WIDTH-1:0] s1_in2_q,  s1_in2_d;

   // Stage 2: presented result and architectural accumulator
   logic             out_vld_q, out_vld_d;
   logic [WIDTH-1:0] out_q,     out_d;
   flags_t           flags_q,   flags_d;
   logic [WIDTH-1:0] acc_q,     acc_d;

   // Handshake terms
   logic s2_adv;
   logic s1_adv;
   logic accept;
   logic xfer;

   // Adder core operands and result
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic             core_cin;
   logic [WIDTH-1:0] core_res;
   flags_t           core_flags;

   // Stall chain: a stage may move when the stage after it can take its contents
   always_comb begin
      s2_adv = ~out_vld_q | out_rdy;
      s1_adv = ~s1_vld_q | s2_adv;
      in_rdy = ~rst & s1_adv;
      accept = in_vld & in_rdy;
      xfer   = s1_vld_q & s2_adv;
   end

   // Route S1 operands onto the single adder; LOAD passes in1 through as in1 + 0
   always_comb begin
      core_a   = s1_in1_q;
      core_b   = s1_in2_q;
      core_cin = 1'b0;
      unique case (s1_op_q)
         OP_ADD: begin
            core_b = s1_in2_q;
         end
         OP_SUB: begin
            core_b   = ~s1_in2_q;
            core_cin = 1'b1;
         end
         OP_ACC: begin
            // acc already reflects every older ACC/LOAD: they updated it on
            // their own S1->S2 edge, which precedes this op's.
            core_a = acc_q;
            core_b = s1_in1_q;
         end
         OP_LOAD: begin
            core_b = '0;
         end
         default: begin
            core_b = s1_in2_q;
         end
      endcase
   end

   sat_add_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (core_a),
      .b     (core_b),
      .cin   (core_cin),
      .res   (core_res),
      .flags (core_flags)
   );

   // Stage 1 next state: capture on acceptance, empty when it drains with nothing new
   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_op_d  = s1_op_q;
      s1_in1_d = s1_in1_q;
      s1_in2_d = s1_in2_q;
      if (s1_adv) begin
         s1_vld_d = accept;
      end
      if (accept) begin
         s1_op_d  = op_e'(op);
         s1_in1_d = in1;
         s1_in2_d = in2;
      end
   end

   // Stage 2 next state: result, flags and accumulator move only on a real transfer
   always_comb begin
      out_vld_d = out_vld_q;
      out_d     = out_q;
      flags_d   = flags_q;
      acc_d     = acc_q;
      if (s2_adv) begin
         out_vld_d = s1_vld_q;
      end
      if (xfer) begin
         out_d   = core_res;
         flags_d = core_flags;
         if ((s1_op_q == OP_ACC) || (s1_op_q == OP_LOAD)) begin
            acc_d = core_res;
         end
      end
   end

   // Pipeline registers; reset discards anything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_op_q   <= OP_ADD;
         s1_in1_q  <= '0;
         s1_in2_q  <= '0;
         out_vld_q <= 1'b0;
         out_q     <= '0;
         flags_q   <= '0;
         acc_q     <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_op_q   <= s1_op_d;
         s1_in1_q  <= s1_in1_d;
         s1_in2_q  <= s1_in2_d;
         out_vld_q <= out_vld_d;
         out_q     <= out_d;
         flags_q   <= flags_d;
         acc_q     <= acc_d;
      end
   end

`ifdef SAT_ALU_STICKY_OV_EN
   logic ov_sticky_q, ov_sticky_d;

   // Sticky overflow: set by any overflowing transfer, which beats a same-cycle clear
   always_comb begin
      ov_sticky_d = (xfer & core_flags.ov) | (ov_sticky_q & ~ov_clr);
   end

   // Sticky overflow register
   always_ff @(posedge clk) begin
      if (rst) begin
         ov_sticky_q <= 1'b0;
      end else begin
         ov_sticky_q <= ov_sticky_d;
      end
   end

   assign ov_sticky = ov_sticky_q;
`else
   // Feature absent: port kept for a stable interface, clear input has no effect
   logic unused_ov_clr;
   assign unused_ov_clr = ov_clr;
   assign ov_sticky     = 1'b0;
`endif

   assign out_vld = out_vld_q;
   assign out     = out_q;
   assign zr      = flags_q.zr;
   assign neg     = flags_q.neg;
   assign ov      = flags_q.ov;
   assign acc     = acc_q;

endmodule

// File: tb/tb_sat_alu_pipe.sv
// Directed self-checking bench for sat_alu_pipe at WIDTH=16.
// Drives inputs 1 time unit after the rising edge and samples there too.
// Covers reset, ADD/SUB saturation, back-to-back ACC, back-pressure, mid-op reset, sticky overflow.
module tb_sat_alu_pipe;

   logic        clk;
   logic        rst;
   logic        in_vld;
   logic        in_rdy;
   logic [1:0]  op;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        out_vld;
   logic        out_rdy;
   logic [15:0] out;
   logic        zr;
   logic        neg;
   logic        ov;
   logic [15:0] acc;
   logic        ov_clr;
   logic        ov_sticky;

   int total;
   int bad;

`ifdef SAT_ALU_STICKY_OV_EN
   localparam logic STK = 1'b1;
`else
   localparam logic STK = 1'b0;
`endif

   sat_alu_pipe #(
      .WIDTH (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out       (out),
      .zr        (zr),
      .neg       (neg),
      .ov        (ov),
      .acc       (acc),
      .ov_clr    (ov_clr),
      .ov_sticky (ov_sticky)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one op, confirm it is not visible after the first edge, then check the result after the second
   task automatic run1(input string tag, input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eo, input logic ez, input logic en, input logic ev);
      in_vld = 1'b1;
      op     = o;
      in1    = a;
      in2    = b;
      #1;
      chk({tag, ".in_rdy"}, 32'(in_rdy), 32'd1);
      tick();
      in_vld = 1'b0;
      chk({tag, ".vld_early"}, 32'(out_vld), 32'd0);
      tick();
      chk({tag, ".vld"}, 32'(out_vld), 32'd1);
      chk({tag, ".out"}, 32'(out), 32'(eo));
      chk({tag, ".zr"},  32'(zr),  32'(ez));
      chk({tag, ".neg"}, 32'(neg), 32'(en));
      chk({tag, ".ov"},  32'(ov),  32'(ev));
   endtask

   logic [15:0] got [4];
   int          nsent;
   int          nrecv;
   logic        fin;

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      in_vld  = 1'b0;
      op      = 2'b00;
      in1     = '0;
      in2     = '0;
      out_rdy = 1'b1;
      ov_clr  = 1'b0;
      nsent   = 0;
      nrecv   = 0;
      fin     = 1'b0;
      for (int i = 0; i < 4; i++) got[i] = '0;

      // Reset state
      tick();
      tick();
      chk("rst.out_vld",   32'(out_vld),   32'd0);
      chk("rst.out",       32'(out),       32'd0);
      chk("rst.zr",        32'(zr),        32'd0);
      chk("rst.neg",       32'(neg),       32'd0);
      chk("rst.ov",        32'(ov),        32'd0);
      chk("rst.acc",       32'(acc),       32'd0);
      chk("rst.ov_sticky", 32'(ov_sticky), 32'd0);
      chk("rst.in_rdy",    32'(in_rdy),    32'd0);
      rst = 1'b0;
      #1;
      chk("rst.in_rdy_rel", 32'(in_rdy), 32'd1);

      // Saturating ADD/SUB in both directions, and an exact zero
      run1("add_pos",  2'b00, 16'h7000, 16'h1000, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      run1("sub_pos",  2'b01, 16'h0000, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      run1("sub_neg",  2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1);
      run1("add_zero", 2'b00, 16'h0005, 16'hFFFB, 16'h0000, 1'b1, 1'b0, 1'b0);
      run1("add_neg",  2'b00, 16'h0003, 16'hFFFA, 16'hFFFD, 1'b0, 1'b1, 1'b0);
      chk("addsub.acc_untouched", 32'(acc), 32'd0);

      // Back-to-back LOAD / ACC / ACC with no idle cycles
      in_vld = 1'b1;
      op     = 2'b11;
      in1    = 16'h7FF0;
      in2    = 16'h0000;
      tick();
      op  = 2'b10;
      in1 = 16'h0020;
      tick();
      chk("b2b.load.vld", 32'(out_vld), 32'd1);
      chk("b2b.load.out", 32'(out),     32'h7FF0);
      chk("b2b.load.ov",  32'(ov),      32'd0);
      chk("b2b.load.acc", 32'(acc),     32'h7FF0);
      op  = 2'b10;
      in1 = 16'hFFFF;
      tick();
      in_vld = 1'b0;
      chk("b2b.acc1.out", 32'(out), 32'h7FFF);
      chk("b2b.acc1.ov",  32'(ov),  32'd1);
      chk("b2b.acc1.neg", 32'(neg), 32'd0);
      chk("b2b.acc1.acc", 32'(acc), 32'h7FFF);
      tick();
      chk("b2b.acc2.vld", 32'(out_vld), 32'd1);
      chk("b2b.acc2.out", 32'(out),     32'h7FFE);
      chk("b2b.acc2.ov",  32'(ov),      32'd0);
      chk("b2b.acc2.acc", 32'(acc),     32'h7FFE);
      tick();
      chk("b2b.drained", 32'(out_vld), 32'd0);

      // Back-pressure: four ADDs k+k offered while out_rdy is low
      out_rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_vld = (nsent < 4);
         op     = 2'b00;
         in1    = 16'(nsent + 1);
         in2    = 16'(nsent + 1);
         #1;
         fin = in_vld & in_rdy;
         if (out_vld && out_rdy && nrecv < 4) begin
            got[nrecv] = out;
            nrecv++;
         end
         tick();
         if (fin) nsent++;
      end
      chk("bp.accepted",   32'(nsent),   32'd2);
      chk("bp.in_rdy",     32'(in_rdy),  32'd0);
      chk("bp.hold.vld",   32'(out_vld), 32'd1);
      chk("bp.hold.out",   32'(out),     32'h0002);
      chk("bp.none_recv",  32'(nrecv),   32'd0);
      out_rdy = 1'b1;
      for (int c = 0; c < 30 && nrecv < 4; c++) begin
         in_vld = (nsent < 4);
         op     = 2'b00;
         in1    = 16'(nsent + 1);
         in2    = 16'(nsent + 1);
         #1;
         fin = in_vld & in_rdy;
         if (out_vld && out_rdy && nrecv < 4) begin
            got[nrecv] = out;
            nrecv++;
         end
         tick();
         if (fin) nsent++;
      end
      in_vld = 1'b0;
      chk("bp.recv_count", 32'(nrecv), 32'd4);
      chk("bp.sent_count", 32'(nsent), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("bp.order[%0d]", i), 32'(got[i]), 32'(2 * (i + 1)));
      end
      chk("bp.no_dup", 32'(out_vld), 32'd0);
      tick();
      chk("bp.no_dup2", 32'(out_vld), 32'd0);

      // Reset with both stages full and a loaded accumulator
      run1("load1234", 2'b11, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
      chk("mid.acc_pre", 32'(acc), 32'h1234);
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      op      = 2'b00;
      in1     = 16'h0001;
      in2     = 16'h0001;
      tick();
      in_vld = 1'b0;
      chk("mid.full.in_rdy", 32'(in_rdy),  32'd0);
      chk("mid.full.vld",    32'(out_vld), 32'd1);
      rst = 1'b1;
      tick();
      chk("mid.rst.vld",    32'(out_vld), 32'd0);
      chk("mid.rst.out",    32'(out),     32'd0);
      chk("mid.rst.flags",  32'({zr, neg, ov}), 32'd0);
      chk("mid.rst.acc",    32'(acc),     32'd0);
      chk("mid.rst.sticky", 32'(ov_sticky), 32'd0);
      chk("mid.rst.in_rdy", 32'(in_rdy),  32'd0);
      rst = 1'b0;
      #1;
      chk("mid.rel.in_rdy", 32'(in_rdy), 32'd1);
      out_rdy = 1'b1;
      tick();
      tick();
      chk("mid.discarded", 32'(out_vld), 32'd0);
      chk("mid.acc_post",  32'(acc),     32'd0);

      // Sticky overflow: set, survives clean ops, clears, and set beats clear
      run1("st.ovf", 2'b00, 16'h7000, 16'h1000, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      chk("st.set", 32'(ov_sticky), 32'(STK));
      for (int k = 0; k < 3; k++) begin
         run1($sformatf("st.clean%0d", k), 2'b00, 16'(k), 16'h0001, 16'(k + 1), 1'b0, 1'b0, 1'b0);
         chk($sformatf("st.keep%0d", k), 32'(ov_sticky), 32'(STK));
      end
      ov_clr = 1'b1;
      tick();
      ov_clr = 1'b0;
      chk("st.clr", 32'(ov_sticky), 32'd0);
      in_vld = 1'b1;
      op     = 2'b01;
      in1    = 16'h8000;
      in2    = 16'h0001;
      tick();
      in_vld = 1'b0;
      ov_clr = 1'b1;
      tick();
      ov_clr = 1'b0;
      chk("st.coinc.ov",  32'(ov),        32'd1);
      chk("st.coinc.set", 32'(ov_sticky), 32'(STK));
      tick();
      chk("st.coinc.hold", 32'(ov_sticky), 32'(STK));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
